// File: rtl/muldiv_alu_sequencer.sv
// Iterative RV32M multiply/divide sequencer that borrows the shared EX-stage ALU one step per granted cycle.
// Optional macro MULDIV_ZERO_BYPASS_EN short-circuits zero-operand multiplies and zero dividends.
module muldiv_alu_sequencer #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [6:0]      alu_ctl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_out
);

  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD = 4'b0000;
  localparam logic [3:0] kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SUB = 4'b1000;
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        f3;
  logic [XLEN-1:0]   op_a, op_b;
  logic [XLEN-1:0]   hi, lo, bmag;      // acc_hi/rem, lo/quo, mcand/dvsr
  logic [XLEN-1:0]   res;
  logic [CNT_W-1:0]  cnt;
  logic              neg_q, neg_r;

  logic              is_div, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, zero_byp, special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN-1:0]   sh;
  logic              take, carry;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   fix_res;

  // Operand decode; funct3[2] selects the divide family, funct3[1] the remainder within it.
  always_comb begin
    is_div   = f3[2];
    a_neg    = (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd6) && op_a[XLEN-1];
    b_neg    = (f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd6) && op_b[XLEN-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    div_zero = is_div && (op_b == '0);
    div_ovf  = is_div && !f3[0] && (op_a == INT_MIN) && (op_b == '1);
`ifdef MULDIV_ZERO_BYPASS_EN
    zero_byp = is_div ? ((op_a == '0) && (op_b != '0)) : ((op_a == '0) || (op_b == '0));
`else
    zero_byp = 1'b0;
`endif
    special  = div_zero || div_ovf || zero_byp;
    if (div_zero)     special_res = f3[1] ? op_a : '1;
    else if (div_ovf) special_res = f3[1] ? '0 : INT_MIN;
    else              special_res = '0;
  end

  // Step helpers: the 33-bit partial remainder is {top, sh}; carry recovers the adder's lost bit.
  always_comb begin
    sh     = {hi[XLEN-2:0], lo[XLEN-1]};
    take   = hi[XLEN-1] || (sh >= bmag);
    carry  = alu_out < hi;
    prod_s = neg_q ? -{hi, lo} : {hi, lo};
    case (f3)
      3'd0:                fix_res = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fix_res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:          fix_res = neg_q ? -lo : lo;
      default:             fix_res = neg_r ? -hi : hi;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_ctl = '0;
    alu_a   = '0;
    alu_b   = '0;
    if (state == ITER) begin
      if (is_div) begin
        alu_ctl = {3'b000, kSAIL_MICROARCHITECTURE_ALUCTL_3to0_SUB};
        alu_a   = sh;
        alu_b   = bmag;
      end else begin
        alu_ctl = {3'b000, kSAIL_MICROARCHITECTURE_ALUCTL_3to0_ADD};
        alu_a   = hi;
        alu_b   = lo[0] ? bmag : '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = PREP;
      PREP: state_nxt = special ? DONE : ITER;
      ITER: if (alu_gnt && cnt == CNT_W'(ITERS - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f3    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      hi    <= '0;
      lo    <= '0;
      bmag  <= '0;
      res   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid && !kill) begin
          f3   <= req_funct3;
          op_a <= req_rs1;
          op_b <= req_rs2;
        end
        PREP: begin
          hi    <= '0;
          lo    <= a_mag;
          bmag  <= b_mag;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          cnt   <= '0;
          if (special) res <= special_res;
        end
        ITER: if (alu_gnt) begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            hi <= take ? alu_out : sh;
            lo <= {lo[XLEN-2:0], take};
          end else begin
            hi <= {carry, alu_out[XLEN-1:1]};
            lo <= {alu_out[0], lo[XLEN-1:1]};
          end
        end
        FIX: res <= fix_res;
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);
  assign alu_req    = (state == ITER);
  assign resp_data  = res;

endmodule

// File: tb/tb_muldiv_alu_sequencer.sv
// Self-checking bench for muldiv_alu_sequencer: behavioural RV32M model, ALU model, directed and random ops.
// Honours MULDIV_ZERO_BYPASS_EN when predicting latency.
module tb_muldiv_alu_sequencer;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  logic        clk, reset;
  logic        req_valid, req_ready, kill;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1, req_rs2;
  logic        resp_valid, resp_ready, busy;
  logic [31:0] resp_data;
  logic        alu_req, alu_gnt;
  logic [6:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, alu_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_exp;
  logic [2:0]  cur_f3;
  logic        exp_live;
  logic        prev_req, prev_gnt;
  logic [70:0] prev_bus;

  muldiv_alu_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .kill(kill),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_ctl(alu_ctl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  // Shared ALU: combinational add/sub.
  assign alu_out = (alu_ctl[3:0] == ALU_SUB) ? alu_a - alu_b : alu_a + alu_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ps;
    logic [63:0] pu;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (f3)
      3'd0: begin ps = sa * sb; return ps[31:0]; end
      3'd1: begin ps = sa * sb; return ps[63:32]; end
      3'd2: begin ps = sa * $signed({32'b0, b}); return ps[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        ps = sa / sb; return ps[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        ps = sa % sb; return ps[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic sp;
    sp = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MULDIV_ZERO_BYPASS_EN
    sp = sp || (f3[2] ? (a == 0) : (a == 0 || b == 0));
`endif
    return sp;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Grant history for the stall-stability check.
  always @(posedge clk) begin
    prev_req <= alu_req;
    prev_gnt <= alu_gnt;
    prev_bus <= {alu_ctl, alu_a, alu_b};
  end

  // Per-cycle compare against the bench's expectations.
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid) begin
        if (exp_live) check("resp_data", resp_data, cur_exp);
        else          check("unexpected_resp", resp_valid, 0);
      end
      if (!alu_req)
        check("alu_idle_zero", {alu_ctl, alu_a, alu_b}, 0);
      else begin
        check("alu_ctl_op", alu_ctl, {3'b000, cur_f3[2] ? ALU_SUB : ALU_ADD});
        if (prev_req && !prev_gnt)
          check("alu_stall_stable", {alu_ctl, alu_a, alu_b}, prev_bus);
      end
      check("busy_vs_ready", busy, !req_ready);
    end
  end

  // Issues one op at a negedge and returns at a negedge after the response handshake.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int gmode, input int rdly, input logic use_lit,
                        input logic [31:0] lit, input int exp_lat);
    int n, nreq, lows, first, last;
    logic sp;
    sp       = is_special(f3, a, b);
    cur_exp  = use_lit ? lit : model(f3, a, b);
    cur_f3   = f3;
    exp_live = 1'b1;
    req_funct3 = f3;
    req_rs1    = a;
    req_rs2    = b;
    req_valid  = 1'b1;
    check("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1; nreq = 0; lows = 0; first = -1; last = -1;
    while (!resp_valid && n < 400) begin
      if (alu_req) begin
        if (first < 0) first = n;
        last = n;
        case (gmode)
          0:       alu_gnt = 1'b1;
          1:       alu_gnt = nreq[0];
          default: alu_gnt = ($urandom_range(0, 3) != 0);
        endcase
        if (!alu_gnt) lows++;
        nreq++;
      end
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      check("resp_timeout", resp_valid, 1);
      exp_live = 1'b0;
      return;
    end
    check("latency", n, sp ? 2 : 35 + lows);
    if (exp_lat >= 0) check("latency_lit", n, exp_lat);
    check("granted_iters", nreq - lows, sp ? 0 : 32);
    if (!sp) check("alu_req_window", {first, last}, {32'd2, 32'(n - 2)});
    repeat (rdly) begin
      check("resp_hold", {resp_valid, req_ready, busy}, 3'b101);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    exp_live   = 1'b0;
    check("post_handshake", {resp_valid, req_ready, busy}, 3'b010);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; kill = 1'b0; resp_ready = 1'b0; alu_gnt = 1'b0;
    req_funct3 = '0; req_rs1 = '0; req_rs2 = '0;
    cur_exp = '0; cur_f3 = '0; exp_live = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {req_ready, resp_valid, busy, alu_req, alu_ctl, alu_a, alu_b, resp_data},
          {4'b1000, 7'd0, 96'd0});
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-computed results.
    run_op(3'd0, 32'd7,          32'd6,          0, 0, 1'b1, 32'h0000_002A, 35);
    run_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 0, 1'b1, 32'h0000_0000, 35);
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 0, 1'b1, 32'hFFFF_FFFE, 35);
    run_op(3'd2, 32'hFFFF_FFFF,  32'd2,          0, 0, 1'b1, 32'hFFFF_FFFF, 35);
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,          0, 0, 1'b1, 32'hFFFF_FFFD, 35);
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,          0, 0, 1'b1, 32'hFFFF_FFFF, 35);
    run_op(3'd5, 32'd100,        32'd7,          0, 0, 1'b1, 32'd14,        35);
    run_op(3'd7, 32'd100,        32'd7,          0, 0, 1'b1, 32'd2,         35);
    run_op(3'd5, 32'd5,          32'd0,          0, 0, 1'b1, 32'hFFFF_FFFF, 2);
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  0, 0, 1'b1, 32'h0000_0000, 2);
    run_op(3'd0, 32'd3,          32'd5,          1, 4, 1'b1, 32'd15,        67);

    // Kill mid-divide, then a fresh multiply accepted the very next cycle.
    cur_f3 = 3'd5; exp_live = 1'b0;
    req_funct3 = 3'd5; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_valid = 1'b1; alu_gnt = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_to_idle", {req_ready, busy, alu_req, resp_valid}, 4'b1000);
    run_op(3'd0, 32'd2, 32'd3, 0, 0, 1'b1, 32'd6, 35);

    // Kill in IDLE blocks a same-cycle accept.
    req_funct3 = 3'd0; req_rs1 = 32'd9; req_rs2 = 32'd9; req_valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0;
    check("kill_blocks_accept", {req_ready, busy}, 2'b10);

    // Randomized ops against the model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      run_op(f3, a, b, ($urandom_range(0, 1) == 0) ? 0 : 2, $urandom_range(0, 2), 1'b0, 32'h0, -1);
    end

    // Reset in the middle of an operation discards it.
    cur_f3 = 3'd1; exp_live = 1'b0;
    req_funct3 = 3'd1; req_rs1 = 32'h1234_5678; req_rs2 = 32'h9ABC_DEF0; req_valid = 1'b1; alu_gnt = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_midop", {req_ready, resp_valid, busy, alu_req, alu_ctl, alu_a, alu_b, resp_data},
          {4'b1000, 7'd0, 96'd0});
    reset = 1'b0;
    @(negedge clk);
    run_op(3'd7, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b1, 32'd1, 35);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
